// File: rtl/byte_serial_logic_unit.sv
// Byte-serial logic unit: applies AND/OR/XOR/NOR one slice per cycle to latched
// operands and assembles the full-width result behind a start/busy/done handshake.
module byte_serial_logic_unit #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   a_lat;
  logic [DATA_W-1:0]   b_lat;
  logic [1:0]          op_lat;
  logic [SLICE_W-1:0]  a_byte;
  logic [SLICE_W-1:0]  b_byte;
  logic [SLICE_W-1:0]  slice_out;
  logic [DATA_W-1:0]   merged;

  assign a_byte = a_lat[cnt*SLICE_W +: SLICE_W];
  assign b_byte = b_lat[cnt*SLICE_W +: SLICE_W];

  // Slice datapath only ever sees the latched copies, never the live inputs.
  always_comb begin
    slice_out = '0;
    case (op_lat)
      2'b00:   slice_out = a_byte & b_byte;
      2'b01:   slice_out = a_byte | b_byte;
      2'b10:   slice_out = a_byte ^ b_byte;
      default: slice_out = ~(a_byte | b_byte);
    endcase
  end

  always_comb begin
    merged = result;
    merged[cnt*SLICE_W +: SLICE_W] = slice_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a_lat  <= '0;
      b_lat  <= '0;
      op_lat <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_lat  <= a;
            b_lat  <= b;
            op_lat <= op;
            result <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          result <= merged;
          if (cnt == LAST) begin
            // zero must see the final byte, so it is derived from merged.
            cnt   <= '0;
            zero  <= (merged == '0);
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serial_logic_unit.sv
// Directed bench for byte_serial_logic_unit: hand-computed vectors, handshake
// timing, ignored starts while busy and mid-operation reset.
module tb_byte_serial_logic_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  byte_serial_logic_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and follow it through to the cycle after done.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [1:0] opv, input logic [31:0] exp, input logic prev_zero);
    int n;
    int busy_cycles;
    a = av; b = bv; op = opv; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~av; b = 32'h0; op = ~opv;  // latched copies must be used
    n = 0;
    busy_cycles = 0;
    while (!done && n < 20) begin
      check({tag, "_busy_run"}, {31'b0, busy}, 32'd1);
      check({tag, "_zero_hold"}, {31'b0, zero}, {31'b0, prev_zero});
      busy_cycles++;
      tick();
      n++;
    end
    if (busy) busy_cycles++;
    check({tag, "_latency"}, n, 32'd4);
    check({tag, "_busy_cycles"}, busy_cycles, 32'd5);
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    check({tag, "_result"}, result, exp);
    check({tag, "_zero"}, {31'b0, zero}, {31'b0, (exp == 32'h0)});
    $display("op %s: a=%08h b=%08h op=%0d result=%08h zero=%0b", tag, av, bv, opv, result, zero);
    tick();
    check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    check({tag, "_busy_end"}, {31'b0, busy}, 32'd0);
    check({tag, "_result_hold"}, result, exp);
  endtask

  initial begin
    int n;
    int dc0;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("idle_busy", {31'b0, busy}, 32'd0);
      check("idle_done", {31'b0, done}, 32'd0);
      check("idle_result", result, 32'd0);
      check("idle_zero", {31'b0, zero}, 32'd0);
      tick();
    end
    $display("reset/idle: busy=%0b done=%0b result=%08h zero=%0b", busy, done, result, zero);

    run_op("or_basic", 32'h12340000, 32'h00005678, 2'b01, 32'h12345678, 1'b0);
    run_op("and", 32'hF0F0AA55, 32'h0FF0FF00, 2'b00, 32'h00F0AA00, 1'b0);
    run_op("or",  32'hF0F0AA55, 32'h0FF0FF00, 2'b01, 32'hFFF0FF55, 1'b0);
    run_op("xor", 32'hF0F0AA55, 32'h0FF0FF00, 2'b10, 32'hFF005555, 1'b0);
    run_op("nor", 32'hF0F0AA55, 32'h0FF0FF00, 2'b11, 32'h000F00AA, 1'b0);
    run_op("and_zero", 32'hAAAAAAAA, 32'h55555555, 2'b00, 32'h00000000, 1'b0);
    run_op("or_ones",  32'hAAAAAAAA, 32'h55555555, 2'b01, 32'hFFFFFFFF, 1'b1);

    // Starts in RUN cycles 2 and 3 and in the done cycle must all be ignored.
    dc0 = done_cnt;
    a = 32'h0F0F0F0F; b = 32'h00FF00FF; op = 2'b10; start = 1'b1;
    tick();                        // cycle 1 of RUN
    start = 1'b0;
    tick();                        // cycle 2
    a = 32'h11111111; b = 32'h22222222; op = 2'b01; start = 1'b1;
    tick();                        // cycle 3
    tick();                        // cycle 4
    start = 1'b0;
    tick();                        // done cycle
    check("busy_ign_done", {31'b0, done}, 32'd1);
    check("busy_ign_result", result, 32'h0FF00FF0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_ign_after", {31'b0, busy}, 32'd0);
    check("busy_ign_pulses", done_cnt - dc0, 32'd1);
    $display("start-while-busy: result=%08h pulses=%0d", 32'h0FF00FF0, done_cnt - dc0);
    run_op("after_ign", 32'h11111111, 32'h22222222, 2'b01, 32'h33333333, 1'b0);

    // Reset after two bytes are written.
    dc0 = done_cnt;
    a = 32'h12340000; b = 32'h00005678; op = 2'b01; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("midrst_partial", result, 32'h00005678);
    rst = 1'b1;
    #1;
    check("midrst_result", result, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_zero", {31'b0, zero}, 32'd0);
    tick();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy) n++;
      tick();
    end
    check("midrst_idle_busy", n, 32'd0);
    check("midrst_no_done", done_cnt - dc0, 32'd0);
    $display("reset mid-op: result=%08h busy=%0b", result, busy);
    run_op("after_rst", 32'hF0F0AA55, 32'h0FF0FF00, 2'b10, 32'hFF005555, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
